mem_io_unit: RTL



---
 rtl/mem_io_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_io_unit.sv
// mem_io_unit: memory-stage responder with call-stack RAM, main/program RAM ports and frame-buffer port.
// Loads and pops return 1 cycle after acceptance; stall_mem_req holds the request while the FB path can't take it.
// FB_WRITE_BUFFER_EN adds a frame-buffer write FIFO; undefined, FB accesses go straight to the port.

`ifdef FB_WRITE_BUFFER_EN
// sync_fifo: generic show-ahead FIFO, head visible combinationally, 1-cycle write-to-head latency.
// No internal protection: caller must not push when full (unless popping) nor pop when empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule
`endif

module mem_io_unit #(
  parameter int FB_FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        main_mem_en,
  input  logic        prog_mem_en,
  input  logic        fb_en,
  input  logic        call_stk_en,
  input  logic        mem_wen,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  call_stk_addr,
  input  logic [11:0] write_data,
  input  logic [13:0] call_stk_write_data,
  output logic [11:0] read_data,
  output logic [13:0] call_stk_read_data,
  input  logic [13:0] prog_cntr_val,
  output logic [31:0] mem_fetch_instruction,
  output logic        mm_en,
  output logic        mm_wen,
  output logic [15:0] mm_addr,
  output logic [11:0] mm_wdata,
  input  logic [11:0] mm_rdata,
  output logic [13:0] pm_fetch_addr,
  input  logic [31:0] pm_fetch_data,
  output logic [13:0] pm_data_addr,
  input  logic [31:0] pm_data_rdata,
  output logic        fb_port_en,
  output logic        fb_port_wen,
  output logic [15:0] fb_port_addr,
  output logic [11:0] fb_port_wdata,
  input  logic [11:0] fb_port_rdata,
  input  logic        fb_busy,
  output logic        stall_mem_req,
  output logic        mem_fault
);
  logic        sel_cs;
  logic        sel_mm;
  logic        sel_fb;
  logic        sel_pm;
  logic [2:0]  en_cnt;
  logic        fb_rd_go;
  logic        unused_bits;
  logic [13:0] cs_ram [256];

  // Fixed priority: call stack > main > frame buffer > program memory.
  assign sel_cs = call_stk_en;
  assign sel_mm = main_mem_en & ~call_stk_en;
  assign sel_fb = fb_en & ~main_mem_en & ~call_stk_en;
  assign sel_pm = prog_mem_en & ~fb_en & ~main_mem_en & ~call_stk_en;
  assign en_cnt = 3'(main_mem_en) + 3'(prog_mem_en) + 3'(fb_en) + 3'(call_stk_en);

  assign mm_en    = sel_mm;
  assign mm_wen   = sel_mm & mem_wen;
  assign mm_addr  = sel_mm ? mem_addr : '0;
  assign mm_wdata = (sel_mm & mem_wen) ? write_data : '0;

  assign pm_fetch_addr         = prog_cntr_val;
  assign mem_fetch_instruction = pm_fetch_data;
  assign pm_data_addr          = mem_addr[13:0];

`ifdef FB_WRITE_BUFFER_EN
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic [27:0] fifo_head;

  // A full FIFO still accepts the write in a cycle that drains the head.
  assign fifo_pop      = ~fb_busy & ~fifo_empty;
  assign fifo_push     = sel_fb & mem_wen & (~fifo_full | fifo_pop);
  assign fb_rd_go      = sel_fb & ~mem_wen & fifo_empty & ~fb_busy;
  assign stall_mem_req = sel_fb & (mem_wen ? (fifo_full & ~fifo_pop) : ~fb_rd_go);

  sync_fifo #(.W(28), .DEPTH(FB_FIFO_DEPTH)) u_fb_fifo (
    .clock    (clock),
    .nreset   (nreset),
    .push     (fifo_push),
    .push_dat ({mem_addr, write_data}),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign fb_port_en    = fifo_pop | fb_rd_go;
  assign fb_port_wen   = fifo_pop;
  assign fb_port_addr  = fifo_pop ? fifo_head[27:12] : (fb_rd_go ? mem_addr : '0);
  assign fb_port_wdata = fifo_pop ? fifo_head[11:0] : '0;
  assign unused_bits   = ^pm_data_rdata[31:12];
`else
  logic fb_go;

  assign fb_go         = sel_fb & ~fb_busy;
  assign fb_rd_go      = fb_go & ~mem_wen;
  assign stall_mem_req = sel_fb & fb_busy;
  assign fb_port_en    = fb_go;
  assign fb_port_wen   = fb_go & mem_wen;
  assign fb_port_addr  = fb_go ? mem_addr : '0;
  assign fb_port_wdata = (fb_go & mem_wen) ? write_data : '0;
  assign unused_bits   = ^{pm_data_rdata[31:12], 1'(FB_FIFO_DEPTH)};
`endif

  always_ff @(posedge clock) begin
    if (sel_cs & mem_wen) cs_ram[call_stk_addr] <= call_stk_write_data;
  end

  // Call-stack port is write-first: a push also returns the pushed value.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      read_data          <= '0;
      call_stk_read_data <= '0;
      mem_fault          <= 1'b0;
    end else begin
      mem_fault <= ((en_cnt > 3'd1) | (sel_pm & mem_wen)) & ~stall_mem_req;
      if (sel_cs)
        call_stk_read_data <= mem_wen ? call_stk_write_data : cs_ram[call_stk_addr];
      if (sel_mm & ~mem_wen)
        read_data <= mm_rdata;
      else if (sel_pm)
        read_data <= mem_wen ? 12'h000 : pm_data_rdata[11:0];
      else if (fb_rd_go)
        read_data <= fb_port_rdata;
    end
  end
endmodule
